// File: rtl/rng_pkg.sv
// Shared definitions for the RNG stream buffer: FSM encodings, the generator
// word width and default sizing.
package rng_pkg;

  localparam int WORD_W        = 64;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_WARMUP    = 16;
  localparam int DEF_REP_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_FAULT  = 2'd2
  } rng_state_t;

endpackage

// File: rtl/rng_fifo.sv
// Power-of-two FIFO for generator words. The head word reads combinationally,
// and the head output is forced to zero while the FIFO is empty.
module rng_fifo
  import rng_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        wr_data,
  output logic [WORD_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rng_stream_buffer.sv
// Buffers PCG generator words behind a warm-up discard window and a
// repetition-count health test; a tripped test flushes and holds in FAULT.
module rng_stream_buffer
  import rng_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int WARMUP    = DEF_WARMUP,
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  input  logic [63:0]            random_in,
  input  logic                   clear_fault,
  output logic [63:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   health_fail,
  output logic [1:0]             state_o
);

  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);

  rng_state_t        state;
  rng_state_t        state_nxt;
  logic [WARM_W-1:0] warm_cnt;
  logic [WARM_W-1:0] warm_cnt_nxt;
  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W-1:0]  rep_cnt_nxt;
  logic [REP_W-1:0]  rep_cand;
  logic              rep_trip;
  logic [WORD_W-1:0] last_word;
  logic              overflow_nxt;
  logic              push;
  logic              pop;
  logic              flush;
  logic              full;
  logic              empty;

  assign out_valid   = !empty && (state != ST_FAULT);
  assign pop         = out_valid && out_ready;
  assign health_fail = (state == ST_FAULT);
  assign state_o     = state;

  // rep_cnt==0 marks "no sample since reset/clear", so last_word is ignored then.
  always_comb begin
    rep_cand = REP_W'(1);
    if (rep_cnt != '0 && random_in == last_word) begin
      rep_cand = rep_cnt + 1'b1;
    end
  end

  assign rep_trip = (rep_cand == REP_W'(REP_LIMIT));

  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    rep_cnt_nxt  = rep_cnt;
    overflow_nxt = overflow;
    push         = 1'b0;
    flush        = 1'b0;
    case (state)
      ST_WARMUP: begin
        if (sample_en) begin
          rep_cnt_nxt = rep_cand;
          if (rep_trip) begin
            state_nxt = ST_FAULT;
            flush     = 1'b1;
          end else begin
            warm_cnt_nxt = warm_cnt + 1'b1;
            if (warm_cnt == WARM_W'(WARMUP - 1)) state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (sample_en) begin
          rep_cnt_nxt = rep_cand;
          if (rep_trip) begin
            state_nxt = ST_FAULT;
            flush     = 1'b1;
          end else if (!full || pop) begin
            push = 1'b1;
          end else begin
            overflow_nxt = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_nxt    = ST_WARMUP;
          warm_cnt_nxt = '0;
          rep_cnt_nxt  = '0;
          overflow_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt    = ST_WARMUP;
        warm_cnt_nxt = '0;
        rep_cnt_nxt  = '0;
        flush        = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_WARMUP;
      warm_cnt <= '0;
      rep_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
      rep_cnt  <= rep_cnt_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (sample_en && (state == ST_WARMUP || state == ST_RUN)) begin
      last_word <= random_in;
    end
  end

  rng_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .wr_data(random_in),
    .rd_data(out_data),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

endmodule

// File: tb/tb_rng_stream_buffer.sv
// Directed bench for rng_stream_buffer with DEPTH=8, WARMUP=16, REP_LIMIT=4.
module tb_rng_stream_buffer;

  logic        clk;
  logic        rst;
  logic        sample_en;
  logic [63:0] random_in;
  logic        clear_fault;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        overflow;
  logic        health_fail;
  logic [1:0]  state_o;

  int checks;
  int failures;

  localparam logic [63:0] REP_WORD = 64'hDEADBEEF_CAFEF00D;

  rng_stream_buffer #(
    .DEPTH    (8),
    .WARMUP   (16),
    .REP_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .random_in  (random_in),
    .clear_fault(clear_fault),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .overflow   (overflow),
    .health_fail(health_fail),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input logic [63:0] w);
    sample_en = 1'b1;
    random_in = w;
    tick();
    sample_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    sample_en   = 1'b0;
    random_in   = 64'd0;
    clear_fault = 1'b0;
    out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check_eq("rst_state",    64'(state_o),     64'd0);
    check_eq("rst_level",    64'(level),       64'd0);
    check_eq("rst_valid",    64'(out_valid),   64'd0);
    check_eq("rst_overflow", 64'(overflow),    64'd0);
    check_eq("rst_health",   64'(health_fail), 64'd0);
    check_eq("rst_data",     out_data,         64'd0);

    // Warm-up: 1..16 discarded, 17 is the first output word.
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      sample(64'(i));
      if (i == 15) check_eq("warm_state_15", 64'(state_o), 64'd0);
    end
    check_eq("warm_run",   64'(state_o),   64'd1);
    check_eq("warm_valid", 64'(out_valid), 64'd0);
    check_eq("warm_level", 64'(level),     64'd0);
    sample(64'd17);
    check_eq("first_valid", 64'(out_valid), 64'd1);
    check_eq("first_data",  out_data,       64'd17);
    check_eq("first_level", 64'(level),     64'd1);
    tick();
    check_eq("first_popped", 64'(level), 64'd0);

    // Backpressure: 10 samples into 8 entries.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample(64'(100 + i));
      if (i == 3) check_eq("bp_hold_early", out_data, 64'd100);
    end
    check_eq("bp_level",    64'(level),     64'd8);
    check_eq("bp_overflow", 64'(overflow),  64'd1);
    check_eq("bp_head",     out_data,       64'd100);
    check_eq("bp_valid",    64'(out_valid), 64'd1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check_eq("clr_run_overflow", 64'(overflow), 64'd1);
    check_eq("clr_run_state",    64'(state_o),  64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("bp_drain_%0d", k), out_data, 64'(100 + k));
      tick();
    end
    check_eq("bp_empty_level", 64'(level),     64'd0);
    check_eq("bp_empty_valid", 64'(out_valid), 64'd0);

    // Repetition fault on the 4th identical word.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) sample(REP_WORD);
    check_eq("rep3_level",  64'(level),       64'd3);
    check_eq("rep3_health", 64'(health_fail), 64'd0);
    sample(REP_WORD);
    check_eq("rep4_health", 64'(health_fail), 64'd1);
    check_eq("rep4_level",  64'(level),       64'd0);
    check_eq("rep4_valid",  64'(out_valid),   64'd0);
    check_eq("rep4_state",  64'(state_o),     64'd2);
    out_ready = 1'b1;
    sample(64'd600);
    sample(64'd601);
    check_eq("fault_ignore_level", 64'(level),   64'd0);
    check_eq("fault_ignore_state", 64'(state_o), 64'd2);

    // Recovery through a fresh warm-up window.
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check_eq("rec_state",    64'(state_o),     64'd0);
    check_eq("rec_overflow", 64'(overflow),    64'd0);
    check_eq("rec_health",   64'(health_fail), 64'd0);
    for (int i = 0; i < 16; i++) begin
      sample(64'(200 + i));
      if (i == 14) check_eq("rec_warm_15", 64'(state_o), 64'd0);
    end
    check_eq("rec_run",   64'(state_o), 64'd1);
    check_eq("rec_level", 64'(level),   64'd0);
    sample(64'd216);
    check_eq("rec_data",      out_data,         64'd216);
    check_eq("rec_valid",     64'(out_valid),   64'd1);
    check_eq("rec_overflow2", 64'(overflow),    64'd0);
    tick();

    // Full FIFO with simultaneous push and pop, across pointer wrap.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) sample(64'(300 + i));
    check_eq("full_level",    64'(level),    64'd8);
    check_eq("full_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("pp_head_%0d", k), out_data, 64'(300 + k));
      sample(64'(308 + k));
      check_eq($sformatf("pp_level_%0d", k), 64'(level), 64'd8);
    end
    check_eq("pp_overflow", 64'(overflow), 64'd0);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("pp_drain_%0d", k), out_data, 64'(304 + k));
      tick();
    end
    check_eq("pp_empty", 64'(level), 64'd0);

    // Mid-stream reset with five words buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) sample(64'(400 + i));
    check_eq("mr_level5", 64'(level), 64'd5);
    rst       = 1'b1;
    sample_en = 1'b1;
    random_in = 64'd405;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    sample_en = 1'b0;
    check_eq("mr_level", 64'(level),     64'd0);
    check_eq("mr_valid", 64'(out_valid), 64'd0);
    check_eq("mr_state", 64'(state_o),   64'd0);
    check_eq("mr_data",  out_data,       64'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) sample(64'(500 + i));
    check_eq("mr_warm_valid", 64'(out_valid), 64'd0);
    sample(64'd516);
    check_eq("mr_first_data",  out_data,   64'd516);
    check_eq("mr_first_level", 64'(level), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
